// File: rtl/kalman_acc_sequencer.sv
// ---------------------------------------------------------------------------
// kalman_acc_sequencer
//
// Upstream feeder for the Kalman core. Block-averages 2^AVG_LOG2 accelerometer
// angle samples (theta/pitch and phi/roll, signed Q2.14). It then presents the
// averages on theta_acc/phi_acc and pulses kf_start for one cycle. The operands
// stay frozen until the core reports kf_done. Samples that arrive while the
// core is busy are dropped and counted.
//
// Optional feature macro: KALMAN_SEQ_ROUND_EN
//   defined   : average = (acc + 2^(AVG_LOG2-1)) >>> AVG_LOG2 (round half up)
//   undefined : average = acc >>> AVG_LOG2 (floor toward -inf)
//
// Parameters
//   AVG_LOG2  log2 of samples per average, 0..4 (0 = pass-through)
//   DW        sample / operand width
//
// Ports
//   clk        in   system clock, rising edge
//   reset      in   synchronous active-low reset
//   in_valid   in   single-cycle strobe qualifying in_theta/in_phi
//   in_theta   in   DW  signed pitch sample
//   in_phi     in   DW  signed roll sample
//   kf_start   out  one-cycle start pulse to the Kalman core
//   theta_acc  out  DW  averaged theta, changes only when a new average loads
//   phi_acc    out  DW  averaged phi, same hold rule
//   kf_done    in   core completion, first high cycle in WAIT counts
//   busy       out  high while a result is loading, starting or in flight
//   drop_cnt   out  8   dropped-sample count, saturates at 255
//   overrun    out  sticky flag, set on the first dropped sample
// ---------------------------------------------------------------------------
module kalman_acc_sequencer #(
    parameter int AVG_LOG2 = 2,
    parameter int DW       = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    input  logic [DW-1:0] in_theta,
    input  logic [DW-1:0] in_phi,
    output logic          kf_start,
    output logic [DW-1:0] theta_acc,
    output logic [DW-1:0] phi_acc,
    input  logic          kf_done,
    output logic          busy,
    output logic [7:0]    drop_cnt,
    output logic          overrun
);

    // Accumulator width: the sum of 2^AVG_LOG2 DW-bit values needs AVG_LOG2
    // extra bits, so it cannot overflow.
    localparam int AW    = DW + AVG_LOG2;
    // The sample index needs at least one bit, even in pass-through mode.
    localparam int IDX_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'((1 << AVG_LOG2) - 1);
    localparam int NCH   = 2;   // channel 0 = theta, channel 1 = phi

`ifdef KALMAN_SEQ_ROUND_EN
    // Half an LSB of the shifted result. This evaluates to 0 when AVG_LOG2 == 0.
    localparam int ROUND_K = (1 << AVG_LOG2) >> 1;
`else
    localparam int ROUND_K = 0;
`endif

    typedef enum logic [1:0] {
        ST_ACCUM = 2'd0,
        ST_LOAD  = 2'd1,
        ST_START = 2'd2,
        ST_WAIT  = 2'd3
    } state_t;

    state_t state_reg;
    state_t state_next;

    // Decoded control strobes, produced by the output process.
    logic accept;   // sample taken into the accumulators
    logic drop;     // sample arrived while busy and is discarded
    logic load;     // averages transfer to the output registers

    logic [IDX_W-1:0] idx_reg;
    logic [IDX_W-1:0] idx_next;

    logic [7:0] drop_cnt_reg;
    logic [7:0] drop_cnt_next;
    logic       overrun_reg;
    logic       overrun_next;

    logic [DW-1:0]        sample     [NCH];
    logic signed [AW-1:0] acc_reg    [NCH];
    logic signed [AW-1:0] acc_next   [NCH];
    logic signed [AW:0]   sum_ext    [NCH];
    logic [DW-1:0]        avg        [NCH];
    logic [DW-1:0]        result_reg [NCH];

    assign sample[0] = in_theta;
    assign sample[1] = in_phi;

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg <= ST_ACCUM;
        end else begin
            state_reg <= state_next;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_ACCUM: begin
                if (in_valid && (idx_reg == IDX_LAST)) begin
                    state_next = ST_LOAD;
                end
            end
            ST_LOAD:  state_next = ST_START;
            ST_START: state_next = ST_WAIT;
            ST_WAIT: begin
                // A kf_done that is held high ends WAIT on its first cycle here.
                if (kf_done) begin
                    state_next = ST_ACCUM;
                end
            end
            default:  state_next = ST_ACCUM;
        endcase
    end

    // -----------------------------------------------------------------------
    // FSM: output / control decode
    // -----------------------------------------------------------------------
    always_comb begin
        kf_start = 1'b0;
        busy     = 1'b1;
        accept   = 1'b0;
        drop     = 1'b0;
        load     = 1'b0;
        case (state_reg)
            ST_ACCUM: begin
                busy   = 1'b0;
                accept = in_valid;
            end
            ST_LOAD: begin
                load = 1'b1;
                drop = in_valid;
            end
            ST_START: begin
                kf_start = 1'b1;
                drop     = in_valid;
            end
            ST_WAIT: begin
                // A sample that coincides with kf_done is still dropped. The
                // return to ACCUM only takes effect on the following cycle.
                drop = in_valid;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Sample index
    // -----------------------------------------------------------------------
    always_comb begin
        idx_next = idx_reg;
        if (load) begin
            idx_next = '0;
        end else if (accept) begin
            idx_next = idx_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            idx_reg <= '0;
        end else begin
            idx_reg <= idx_next;
        end
    end

    // -----------------------------------------------------------------------
    // Per-channel accumulate / average / operand hold
    // -----------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_chan
            always_comb begin
                acc_next[gi] = acc_reg[gi];
                if (load) begin
                    acc_next[gi] = '0;
                end else if (accept) begin
                    acc_next[gi] = acc_reg[gi] + AW'($signed(sample[gi]));
                end
            end

            // One guard bit ahead of the shift keeps the rounding add exact.
            // The arithmetic shift then floors toward -inf.
            assign sum_ext[gi] = {acc_reg[gi][AW-1], acc_reg[gi]} + (AW+1)'(ROUND_K);
            assign avg[gi]     = DW'(sum_ext[gi] >>> AVG_LOG2);

            always_ff @(posedge clk) begin
                if (!reset) begin
                    acc_reg[gi]    <= '0;
                    result_reg[gi] <= '0;
                end else begin
                    acc_reg[gi] <= acc_next[gi];
                    if (load) begin
                        result_reg[gi] <= avg[gi];
                    end
                end
            end
        end
    endgenerate

    assign theta_acc = result_reg[0];
    assign phi_acc   = result_reg[1];

    // -----------------------------------------------------------------------
    // Drop accounting: the counter saturates and the overrun flag is sticky.
    // Only reset clears them.
    // -----------------------------------------------------------------------
    always_comb begin
        drop_cnt_next = drop_cnt_reg;
        overrun_next  = overrun_reg;
        if (drop) begin
            overrun_next = 1'b1;
            if (drop_cnt_reg != 8'hFF) begin
                drop_cnt_next = drop_cnt_reg + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            drop_cnt_reg <= '0;
            overrun_reg  <= 1'b0;
        end else begin
            drop_cnt_reg <= drop_cnt_next;
            overrun_reg  <= overrun_next;
        end
    end

    assign drop_cnt = drop_cnt_reg;
    assign overrun  = overrun_reg;

endmodule
